// File: rtl/param_data_array_pkg.sv
// Shared types and helpers for the parametrised cache data array.
// Line and way-select widths are derived per instance; the defaults here describe the stock configuration.
package param_data_array_pkg;

  typedef enum logic {
    INIT  = 1'b0,
    READY = 1'b1
  } state_e;

  localparam int DEF_S_INDEX    = 3;
  localparam int DEF_NUM_WAYS   = 4;
  localparam int DEF_LINE_BYTES = 32;
  localparam int LINE_BITS      = 8 * DEF_LINE_BYTES;
  localparam int WAY_W          = $clog2(DEF_NUM_WAYS);

  // One byte of the bypass-merged line: a same-set write wins over the stored byte.
  function automatic logic [7:0] merge_byte(input logic [7:0] stored,
                                            input logic [7:0] wdata,
                                            input logic       hit);
    return hit ? wdata : stored;
  endfunction

endpackage

// File: rtl/param_data_array_way_bank.sv
// One way of the data array: 2^S_INDEX lines, byte-enable write port,
// registered read with write-first merge of a same-edge write.
module data_way_bank
  import param_data_array_pkg::*;
#(
  parameter int S_INDEX    = DEF_S_INDEX,
  parameter int LINE_BYTES = DEF_LINE_BYTES
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [LINE_BYTES-1:0]     we,
  input  logic [S_INDEX-1:0]        waddr,
  input  logic [8*LINE_BYTES-1:0]   wdata,
  input  logic                      re,
  input  logic [S_INDEX-1:0]        raddr,
  output logic [8*LINE_BYTES-1:0]   rd_data
);

  localparam int SETS   = 2 ** S_INDEX;
  localparam int LINE_W = 8 * LINE_BYTES;

  logic [LINE_W-1:0] mem [SETS];
  logic [LINE_W-1:0] stored;
  logic [LINE_W-1:0] merged;
  logic [LINE_W-1:0] rd_data_d;
  logic [LINE_W-1:0] rd_data_q;
  logic              same_set;

  assign stored   = mem[raddr];
  assign same_set = (waddr == raddr);

  for (genvar gi = 0; gi < LINE_BYTES; gi++) begin : g_byte
    assign merged[8*gi +: 8] = merge_byte(stored[8*gi +: 8], wdata[8*gi +: 8],
                                          we[gi] && same_set);
  end

  always_comb begin
    rd_data_d = rd_data_q;
    if (re) rd_data_d = merged;
  end

  always_ff @(posedge clk) begin
    if (rst) rd_data_q <= '0;
    else     rd_data_q <= rd_data_d;
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < LINE_BYTES; i++) begin
      if (we[i]) mem[waddr][8*i +: 8] <= wdata[8*i +: 8];
    end
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/param_data_array.sv
// Set-associative cache data array: NUM_WAYS banks read in parallel,
// with a post-reset sweep that zeroes every set before reporting ready.
module param_data_array
  import param_data_array_pkg::*;
#(
  parameter int S_INDEX    = DEF_S_INDEX,
  parameter int NUM_WAYS   = DEF_NUM_WAYS,
  parameter int LINE_BYTES = DEF_LINE_BYTES
) (
  input  logic                               clk,
  input  logic                               rst,
  output logic                               ready,
  input  logic                               rd_en,
  input  logic [S_INDEX-1:0]                 rd_index,
  output logic                               rd_valid,
  output logic [NUM_WAYS*8*LINE_BYTES-1:0]   rd_data,
  input  logic [$clog2(NUM_WAYS)-1:0]        wr_way,
  input  logic [S_INDEX-1:0]                 wr_index,
  input  logic [LINE_BYTES-1:0]              wr_be,
  input  logic [8*LINE_BYTES-1:0]            wr_data
);

  localparam int LINE_W    = 8 * LINE_BYTES;
  localparam int WAY_SEL_W = $clog2(NUM_WAYS);

  state_e             state_q, state_d;
  logic [S_INDEX-1:0] init_cnt_q, init_cnt_d;
  logic               ready_q, ready_d;
  logic               rd_valid_q, rd_valid_d;

  always_comb begin
    state_d    = state_q;
    init_cnt_d = init_cnt_q;
    ready_d    = ready_q;
    rd_valid_d = 1'b0;
    case (state_q)
      INIT: begin
        init_cnt_d = init_cnt_q + 1'b1;
        // Terminal compare: the wrapped counter is never looked at again.
        if (init_cnt_q == '1) begin
          state_d = READY;
          ready_d = 1'b1;
        end
      end
      READY: rd_valid_d = rd_en;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= INIT;
      init_cnt_q <= '0;
      ready_q    <= 1'b0;
      rd_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      init_cnt_q <= init_cnt_d;
      ready_q    <= ready_d;
      rd_valid_q <= rd_valid_d;
    end
  end

  logic               in_init;
  logic [S_INDEX-1:0] bank_waddr;
  logic [LINE_W-1:0]  bank_wdata;

  assign in_init    = (state_q == INIT);
  assign bank_waddr = in_init ? init_cnt_q : wr_index;
  assign bank_wdata = in_init ? '0 : wr_data;

  for (genvar gi = 0; gi < NUM_WAYS; gi++) begin : g_way
    logic [LINE_BYTES-1:0] bank_we;

    assign bank_we = in_init ? '1 :
                     (wr_way == WAY_SEL_W'(gi)) ? wr_be : '0;

    data_way_bank #(
      .S_INDEX    (S_INDEX),
      .LINE_BYTES (LINE_BYTES)
    ) u_bank (
      .clk     (clk),
      .rst     (rst),
      .we      (bank_we),
      .waddr   (bank_waddr),
      .wdata   (bank_wdata),
      .re      (rd_valid_d),
      .raddr   (rd_index),
      .rd_data (rd_data[gi*LINE_W +: LINE_W])
    );
  end

  assign ready    = ready_q;
  assign rd_valid = rd_valid_q;

endmodule

// File: tb/tb_param_data_array.sv
// Bench for param_data_array: directed table, init/reset sequences and
// randomized traffic checked against a byte-level storage model.
module tb_param_data_array;

  localparam int SI   = 3;
  localparam int NW   = 4;
  localparam int LB   = 32;
  localparam int LBIT = 8 * LB;
  localparam int DW   = NW * LBIT;
  localparam int SETS = 2 ** SI;

  logic            clk = 1'b0;
  logic            rst;
  logic            ready;
  logic            rd_en;
  logic [SI-1:0]   rd_index;
  logic            rd_valid;
  logic [DW-1:0]   rd_data;
  logic [1:0]      wr_way;
  logic [SI-1:0]   wr_index;
  logic [LB-1:0]   wr_be;
  logic [LBIT-1:0] wr_data;

  param_data_array #(.S_INDEX(SI), .NUM_WAYS(NW), .LINE_BYTES(LB)) dut (
    .clk(clk), .rst(rst), .ready(ready),
    .rd_en(rd_en), .rd_index(rd_index), .rd_valid(rd_valid), .rd_data(rd_data),
    .wr_way(wr_way), .wr_index(wr_index), .wr_be(wr_be), .wr_data(wr_data)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference storage, one byte per entry.
  logic [7:0]    mem_b [SETS][NW][LB];
  logic          exp_valid_m;
  logic [DW-1:0] exp_data_m;

  typedef struct {
    logic          rd_en;
    logic [SI-1:0] rd_index;
    logic [1:0]    wr_way;
    logic [SI-1:0] wr_index;
    logic [LB-1:0] wr_be;
    logic [LBIT-1:0] wr_data;
    logic          exp_valid;
    logic [DW-1:0] exp_data;
  } vec_t;

  vec_t vecs[9];

  task automatic chk_bit(input string name, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b want %b", name, act, exp);
    end
  endtask

  task automatic chk_int(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  task automatic chk_line(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    int fw;
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      fw = 0;
      for (int w = NW - 1; w >= 0; w--)
        if (act[w*LBIT +: LBIT] !== exp[w*LBIT +: LBIT]) fw = w;
      $display("FAIL %s way %0d: got %h want %h", name, fw,
               act[fw*LBIT +: LBIT], exp[fw*LBIT +: LBIT]);
    end
  endtask

  task automatic model_clear();
    for (int s = 0; s < SETS; s++)
      for (int w = 0; w < NW; w++)
        for (int b = 0; b < LB; b++) mem_b[s][w][b] = 8'h00;
  endtask

  // Predict the outcome of one READY-state edge, then commit the write.
  task automatic model_edge();
    logic [7:0] v;
    exp_valid_m = rd_en;
    if (rd_en) begin
      for (int w = 0; w < NW; w++)
        for (int b = 0; b < LB; b++) begin
          v = mem_b[rd_index][w][b];
          if (wr_be[b] && wr_index == rd_index && int'(wr_way) == w) v = wr_data[8*b +: 8];
          exp_data_m[(w*LB + b)*8 +: 8] = v;
        end
    end
    for (int b = 0; b < LB; b++)
      if (wr_be[b]) mem_b[wr_index][wr_way][b] = wr_data[8*b +: 8];
  endtask

  task automatic cycle(input logic re, input logic [SI-1:0] ri, input logic [1:0] ww,
                       input logic [SI-1:0] wi, input logic [LB-1:0] be, input logic [LBIT-1:0] wd);
    rd_en = re; rd_index = ri; wr_way = ww; wr_index = wi; wr_be = be; wr_data = wd;
    $display("txn rd=%0b set=%0d | wr way=%0d set=%0d be=%h", re, ri, ww, wi, be);
    model_edge();
    @(posedge clk); #1;
  endtask

  task automatic reset_and_sweep(input int hold);
    int cnt;
    rst = 1'b1; rd_en = 1'b0; wr_be = '0;
    repeat (hold) begin @(posedge clk); #1; end
    chk_bit("reset_ready", ready, 1'b0);
    chk_bit("reset_rd_valid", rd_valid, 1'b0);
    chk_line("reset_rd_data", rd_data, '0);
    rst = 1'b0;
    // Reads and a write to set 0 during the sweep must both be ignored.
    rd_en = 1'b1; rd_index = 0; wr_way = 0; wr_index = 0; wr_be = '1; wr_data = '1;
    cnt = 0;
    while (cnt < 20) begin
      @(posedge clk); #1;
      cnt++;
      chk_bit("init_rd_valid", rd_valid, 1'b0);
      if (ready === 1'b1) break;
    end
    chk_int("init_cycles_to_ready", cnt, SETS);
    rd_en = 1'b0; wr_be = '0;
    model_clear();
    exp_data_m = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; rd_en = 1'b0; rd_index = '0; wr_way = '0; wr_index = '0; wr_be = '0; wr_data = '0;
    exp_valid_m = 1'b0; exp_data_m = '0;

    vecs[0] = '{1'b0, 3'd0, 2'd1, 3'd2, 32'h0000_000F, 256'hA3A2A1A0, 1'b0, '0};
    vecs[1] = '{1'b1, 3'd2, 2'd0, 3'd0, 32'h0, 256'h0, 1'b1,
                {256'h0, 256'h0, 256'hA3A2A1A0, 256'h0}};
    vecs[2] = '{1'b1, 3'd4, 2'd3, 3'd4, 32'hFFFF_FFFF, 256'hDEAD_BEEF, 1'b1,
                {256'hDEAD_BEEF, 256'h0, 256'h0, 256'h0}};
    vecs[3] = '{1'b1, 3'd7, 2'd0, 3'd6, 32'hFFFF_FFFF, 256'h1234_5678, 1'b1, '0};
    vecs[4] = '{1'b1, 3'd6, 2'd0, 3'd0, 32'h0, 256'h0, 1'b1,
                {256'h0, 256'h0, 256'h0, 256'h1234_5678}};
    vecs[5] = '{1'b1, 3'd0, 2'd0, 3'd0, 32'h0, 256'h0, 1'b1, '0};
    vecs[6] = '{1'b1, 3'd1, 2'd0, 3'd0, 32'h0, 256'h0, 1'b1, '0};
    vecs[7] = '{1'b1, 3'd2, 2'd0, 3'd0, 32'h0, 256'h0, 1'b1,
                {256'h0, 256'h0, 256'hA3A2A1A0, 256'h0}};
    vecs[8] = '{1'b0, 3'd0, 2'd0, 3'd0, 32'h0, 256'h0, 1'b0,
                {256'h0, 256'h0, 256'hA3A2A1A0, 256'h0}};

    reset_and_sweep(2);
    chk_bit("ready_after_sweep", ready, 1'b1);
    cycle(1'b1, 3'd5, 2'd0, 3'd0, '0, '0);
    chk_line("set5_zero", rd_data, '0);
    cycle(1'b1, 3'd0, 2'd0, 3'd0, '0, '0);
    chk_line("set0_init_write_ignored", rd_data, '0);

    foreach (vecs[i]) begin
      cycle(vecs[i].rd_en, vecs[i].rd_index, vecs[i].wr_way, vecs[i].wr_index,
            vecs[i].wr_be, vecs[i].wr_data);
      chk_bit($sformatf("vec%0d_rd_valid", i), rd_valid, vecs[i].exp_valid);
      chk_line($sformatf("vec%0d_rd_data", i), rd_data, vecs[i].exp_data);
    end

    for (int n = 0; n < 300; n++) begin
      logic [LB-1:0]   be;
      logic [LBIT-1:0] wd;
      case ($urandom_range(0, 3))
        0:       be = '0;
        1:       be = '1;
        default: be = LB'($urandom);
      endcase
      wd = {8{$urandom}};
      cycle($urandom_range(0, 3) != 0, SI'($urandom_range(0, SETS-1)), 2'($urandom_range(0, NW-1)),
            SI'($urandom_range(0, SETS-1)), be, wd);
      chk_bit("rand_rd_valid", rd_valid, exp_valid_m);
      chk_line("rand_rd_data", rd_data, exp_data_m);
    end

    cycle(1'b0, 3'd0, 2'd2, 3'd3, '1, {8{32'h5A5A_C3C3}});
    cycle(1'b1, 3'd3, 2'd0, 3'd0, '0, '0);
    chk_line("set3_filled", rd_data, exp_data_m);
    reset_and_sweep(1);
    cycle(1'b1, 3'd3, 2'd0, 3'd0, '0, '0);
    chk_bit("post_reset_rd_valid", rd_valid, 1'b1);
    chk_line("set3_recleared", rd_data, '0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
